// File: rtl/alu_op_scheduler_pkg.sv
// Shared types and helpers for the ALU op scheduler: request payload, opcodes and
// the condition-flag evaluation used in the execute stage.
package AluSched_pkg;

  localparam int unsigned ALU_N_REGS  = 16;
  localparam int unsigned ALU_N_FLAGS = 4;
  localparam int unsigned ALU_REG_AW  = $clog2(ALU_N_REGS);
  localparam int unsigned ALU_COND_W  = $clog2(ALU_N_FLAGS + 1);

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  localparam logic [ALU_COND_W-1:0] COND_ALWAYS = '0;

  typedef struct packed {
    logic                  opcode;
    logic                  op1_imm;
    logic [31:0]           op1;
    logic                  op2_imm;
    logic [31:0]           op2;
    logic [ALU_REG_AW-1:0] dest;
    logic [ALU_COND_W-1:0] cond_sel;
  } alu_req_t;

  // Selects above ALU_N_FLAGS match no flag and therefore never pass.
  function automatic logic alu_cond_pass(input logic [ALU_N_FLAGS-1:0] flags,
                                         input logic [ALU_COND_W-1:0]  cond_sel);
    logic pass;
    pass = (cond_sel == COND_ALWAYS);
    for (int unsigned k = 0; k < ALU_N_FLAGS; k++) begin
      if (32'(cond_sel) == k + 1) pass = flags[k];
    end
    return pass;
  endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id
);

  always_comb begin
    logic found;
    int   idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < int'(N_REQ); off++) begin
      idx = (int'(rr_ptr) + off) % int'(N_REQ);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-stage add/sub scheduler sharing one ALU and register file among N_REQ requesters.
// Define ALU_SCHED_BYPASS_EN to forward S2 results into S1 instead of stalling on RAW.
module alu_op_scheduler
  import AluSched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned N_REGS  = ALU_N_REGS,
  parameter int unsigned N_FLAGS = ALU_N_FLAGS,
  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned RAW = $clog2(N_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  alu_req_t [N_REQ-1:0]   req_data,
  output logic                   done_valid,
  output logic [IDW-1:0]         done_id,
  output logic                   done_executed,
  output logic [31:0]            done_value,
  input  logic [RAW-1:0]         rd_addr,
  output logic [31:0]            rd_data,
  input  logic                   flag_wr_en,
  input  logic [N_FLAGS-1:0]     flag_wr_data
);

  logic [31:0]        regs_q [N_REGS];
  logic [N_FLAGS-1:0] flags_q;
  logic [IDW-1:0]     rr_ptr_q;

  logic               s1_valid_q;
  logic [IDW-1:0]     s1_id_q;
  alu_req_t           s1_req_q;

  logic               s2_valid_q;
  logic [IDW-1:0]     s2_id_q;
  logic               s2_opcode_q;
  logic [31:0]        s2_a_q, s2_b_q;
  logic [RAW-1:0]     s2_dest_q;
  logic [ALU_COND_W-1:0] s2_cond_q;

  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     grant_id;
  logic               accept, stall, advance;
  logic               s2_exec, haz1, haz2;
  logic [31:0]        s2_result, op1_raw, op2_raw, op1_val, op2_val;
  logic [RAW-1:0]     s1_a_addr, s1_b_addr;

  // Reset also gates the arbiter so req_ready stays low while rst_n is asserted.
  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .enable  (rst_n & ~stall),
    .grant   (grant),
    .grant_id(grant_id)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign rd_data   = regs_q[rd_addr];

  // Execute stage
  assign s2_exec   = s2_valid_q & alu_cond_pass(flags_q, s2_cond_q);
  assign s2_result = (s2_opcode_q == ALU_SUB) ? (s2_a_q - s2_b_q) : (s2_a_q + s2_b_q);

  assign done_valid    = s2_valid_q;
  assign done_id       = s2_id_q;
  assign done_executed = s2_exec;
  assign done_value    = s2_exec ? s2_result : 32'd0;

  // Operand fetch stage
  assign s1_a_addr = s1_req_q.op1[RAW-1:0];
  assign s1_b_addr = s1_req_q.op2[RAW-1:0];
  assign op1_raw   = s1_req_q.op1_imm ? s1_req_q.op1 : regs_q[s1_a_addr];
  assign op2_raw   = s1_req_q.op2_imm ? s1_req_q.op2 : regs_q[s1_b_addr];

  // Only an S2 op that will actually write can create a hazard.
  assign haz1 = s1_valid_q & ~s1_req_q.op1_imm & s2_exec & (s1_a_addr == s2_dest_q);
  assign haz2 = s1_valid_q & ~s1_req_q.op2_imm & s2_exec & (s1_b_addr == s2_dest_q);

`ifdef ALU_SCHED_BYPASS_EN
  assign stall   = 1'b0;
  assign op1_val = haz1 ? s2_result : op1_raw;
  assign op2_val = haz2 ? s2_result : op2_raw;
`else
  assign stall   = haz1 | haz2;
  assign op1_val = op1_raw;
  assign op2_val = op2_raw;
`endif

  assign advance = s1_valid_q & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_REGS); i++) regs_q[i] <= '0;
      flags_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (s2_exec)    regs_q[s2_dest_q] <= s2_result;
      if (flag_wr_en) flags_q <= flag_wr_data;
      if (accept) begin
        rr_ptr_q <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_req_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      s2_opcode_q <= 1'b0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_dest_q   <= '0;
      s2_cond_q   <= '0;
    end else begin
      // A stalled S1 holds its op while S2 takes a bubble.
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_id_q  <= grant_id;
          s1_req_q <= req_data[grant_id];
        end
      end
      s2_valid_q <= advance;
      if (advance) begin
        s2_id_q     <= s1_id_q;
        s2_opcode_q <= s1_req_q.opcode;
        s2_a_q      <= op1_val;
        s2_b_q      <= op2_val;
        s2_dest_q   <= s1_req_q.dest;
        s2_cond_q   <= s1_req_q.cond_sel;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: a sequential reference model predicts each
// accepted op, and a scoreboard matches retirements by order and cycle.
module tb_alu_op_scheduler;
  import AluSched_pkg::*;

  localparam int N_REQ = 4;
`ifdef ALU_SCHED_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        exec;
    logic [31:0] val;
    int          due;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  alu_req_t [N_REQ-1:0]  req_data;
  logic                  done_valid;
  logic [1:0]            done_id;
  logic                  done_executed;
  logic [31:0]           done_value;
  logic [3:0]            rd_addr;
  logic [31:0]           rd_data;
  logic                  flag_wr_en;
  logic [3:0]            flag_wr_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mrr      = 0;
  logic [31:0] mregs [16];
  logic [3:0]  mflags;
  exp_t        sb [$];

  alu_op_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .done_executed(done_executed),
    .done_value   (done_value),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .flag_wr_en   (flag_wr_en),
    .flag_wr_data (flag_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic alu_req_t mk(input logic opc, input logic i1, input logic [31:0] a,
                                  input logic i2, input logic [31:0] b,
                                  input logic [3:0] dest, input logic [2:0] cs);
    alu_req_t r;
    r.opcode = opc; r.op1_imm = i1; r.op1 = a; r.op2_imm = i2; r.op2 = b;
    r.dest = dest; r.cond_sel = cs;
    return r;
  endfunction

  // Sequential ISA model: ops apply in acceptance order.
  task automatic model_exec(input int id, input alu_req_t r, output exp_t e);
    logic [31:0] a, b, res;
    logic        pass;
    a = r.op1_imm ? r.op1 : mregs[r.op1[3:0]];
    b = r.op2_imm ? r.op2 : mregs[r.op2[3:0]];
    res = r.opcode ? a - b : a + b;
    if (r.cond_sel == 3'd0)      pass = 1'b1;
    else if (r.cond_sel > 3'd4)  pass = 1'b0;
    else                         pass = mflags[int'(r.cond_sel) - 1];
    if (pass) mregs[r.dest] = res;
    e.id = id; e.exec = pass; e.val = pass ? res : 32'd0; e.due = 0;
  endtask

  task automatic tick(input bit expect_stall);
    logic [N_REQ-1:0] exp_ready;
    int   gid;
    exp_t e;
    logic ev;
    #1;
    exp_ready = '0;
    gid = -1;
    if (!expect_stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (mrr + k) % N_REQ;
        if (gid < 0 && req_valid[idx]) gid = idx;
      end
    end
    if (gid >= 0) exp_ready[gid] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    if (expect_stall && sb.size() > 0) sb[sb.size()-1].due++;
    @(posedge clk);
    cyc++;
    if (gid >= 0) begin
      model_exec(gid, req_data[gid], e);
      e.due = cyc + 1;
      sb.push_back(e);
      mrr = (gid + 1) % N_REQ;
    end
    if (flag_wr_en) mflags = flag_wr_data;
    #1;
    ev = (sb.size() > 0) && (sb[0].due == cyc);
    chk("done_valid", 32'(done_valid), 32'(ev));
    if (ev) begin
      e = sb.pop_front();
      chk("done_id", 32'(done_id), 32'(e.id));
      chk("done_executed", 32'(done_executed), 32'(e.exec));
      chk("done_value", done_value, e.val);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '1; req_data = '0; rd_addr = '0;
    flag_wr_en = 1'b0; flag_wr_data = '0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflags = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk_reg("rst_r0", 4'd0, 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // ADD imm 5 + imm 7 -> r3 from requester 0
    req_data[0] = mk(ALU_ADD, 1, 32'd5, 1, 32'd7, 4'd3, 3'd0);
    req_valid = 4'b0001;
    tick(0);
    req_valid = '0;
    repeat (2) tick(0);
    chk_reg("r3_add", 4'd3, 32'd12);

    // SUB 0 - 1 wraps; from requester 3 so the pointer returns to 0
    req_data[3] = mk(ALU_SUB, 1, 32'd0, 1, 32'd1, 4'd2, 3'd0);
    req_valid = 4'b1000;
    tick(0);
    req_valid = '0;
    repeat (2) tick(0);
    chk_reg("r2_wrap", 4'd2, 32'hFFFF_FFFF);

    // All four requesters contending for 8 cycles
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i] = mk(ALU_ADD, 1, 32'(100 * i), 1, 32'(i + 1), 4'(8 + i), 3'd0);
    end
    req_valid = 4'b1111;
    repeat (8) tick(0);
    req_valid = '0;
    repeat (2) tick(0);
    chk_reg("r11_rr", 4'd11, 32'd304);

    // Condition flags: only flag 1 set
    flag_wr_data = 4'b0010; flag_wr_en = 1'b1;
    tick(0);
    flag_wr_en = 1'b0;
    req_data[1] = mk(ALU_ADD, 1, 32'd1, 1, 32'd1, 4'd5, 3'd1);
    req_valid = 4'b0010;
    tick(0);
    req_data[1] = mk(ALU_ADD, 1, 32'd1, 1, 32'd1, 4'd6, 3'd2);
    tick(0);
    req_data[1] = mk(ALU_ADD, 1, 32'd9, 1, 32'd9, 4'd7, 3'd7);
    tick(0);
    req_valid = '0;
    repeat (2) tick(0);
    chk_reg("r5_cond_fail", 4'd5, 32'd0);
    chk_reg("r6_cond_pass", 4'd6, 32'd2);
    chk_reg("r7_cond_never", 4'd7, 32'd0);

    // RAW hazard: r1 = 10 + 0, then r4 = r1 - 3
    req_data[0] = mk(ALU_ADD, 1, 32'd10, 1, 32'd0, 4'd1, 3'd0);
    req_valid = 4'b0001;
    tick(0);
    req_data[0] = mk(ALU_SUB, 0, 32'd1, 1, 32'd3, 4'd4, 3'd0);
    tick(0);
    req_data[2] = mk(ALU_ADD, 1, 32'd20, 1, 32'd22, 4'd13, 3'd0);
    req_valid = 4'b0100;
    tick(!BYPASS);
    tick(0);
    req_valid = '0;
    repeat (3) tick(0);
    chk_reg("r4_raw", 4'd4, 32'd7);
    chk_reg("r13_after_raw", 4'd13, 32'd42);

    // Reset with ops in flight
    req_data[0] = mk(ALU_ADD, 1, 32'd1, 1, 32'd2, 4'd14, 3'd0);
    req_data[1] = mk(ALU_ADD, 1, 32'd3, 1, 32'd4, 4'd15, 3'd0);
    req_valid = 4'b0011;
    tick(0);
    tick(0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflags = '0;
    mrr = 0;
    chk("rst_mid_done_valid", 32'(done_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_done_valid", 32'(done_valid), 32'd0);
    for (int i = 0; i < 16; i++) chk_reg("rst_reg_zero", 4'(i), 32'd0);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    tick(0);
    req_valid = '0;
    repeat (3) tick(0);
    chk_reg("r15_post_rst", 4'd15, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
